// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory-access stage: MEM control field layout,
// MUX/LEN codes and the bus FSM states.
package mem_access_unit_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned CTRL_W   = 6;
    localparam int unsigned MUX_LSB  = 4;
    localparam int unsigned SIGN_BIT = 3;
    localparam int unsigned LEN_LSB  = 1;
    localparam int unsigned WEN_BIT  = 0;
    localparam int unsigned CNT_W    = 16;

    localparam logic [1:0] MUX_ALU  = 2'd0;
    localparam logic [1:0] MUX_MEM  = 2'd1;
    localparam logic [1:0] MUX_IMM  = 2'd2;

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Half needs addr[0]==0, word needs addr[1:0]==0; bytes never misalign.
    function automatic logic is_misaligned(input logic [1:0] len, input logic [1:0] lo);
        logic r;
        case (len)
            LEN_BYTE: r = 1'b0;
            LEN_HALF: r = lo[0];
            default:  r = (lo != 2'b00);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane helper: store data replication / write mask and load extract / extend.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]      len,
    input  logic [1:0]      addr_lo,
    input  logic            sign,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] wdata_rep,
    output logic [3:0]      wmask,
    output logic [XLEN-1:0] rdata_ext
);

    logic [XLEN-1:0] lane;

    always_comb begin
        lane      = rdata >> {addr_lo, 3'b000};
        wdata_rep = wdata;
        wmask     = 4'b1111;
        rdata_ext = rdata;
        case (len)
            LEN_BYTE: begin
                wdata_rep = {4{wdata[7:0]}};
                wmask     = 4'b0001 << addr_lo;
                rdata_ext = {{24{sign & lane[7]}}, lane[7:0]};
            end
            LEN_HALF: begin
                wdata_rep = {2{wdata[15:0]}};
                wmask     = 4'b0011 << addr_lo;
                rdata_ext = {{16{sign & lane[15]}}, lane[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns decoded MEM control into a req/gnt/rvalid
// bus transaction, stalling upstream while it is outstanding.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] mem_ctrl_i,
    input  logic [XLEN-1:0]   aluout_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   imm_i,
    output logic              stall_o,
    output logic [XLEN-1:0]   result_o,
    output logic              done_o,
    output logic              misaligned_o,
    output logic              bus_err_o,
    output logic              req_o,
    output logic              we_o,
    output logic [XLEN-1:0]   addr_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [3:0]        wmask_o,
    input  logic              gnt_i,
    input  logic              rvalid_i,
    input  logic [XLEN-1:0]   rdata_i
);

    state_e           state_q, state_n;
    logic             is_store_q;
    logic [1:0]       len_q;
    logic             sign_q;
    logic [1:0]       addr_lo_q;
    logic [XLEN-1:0]  data_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0]       mux;
    logic [1:0]       len;
    logic             wen_n;
    logic             access;
    logic             timeout_hit;
    logic             go_c, mis_det_c, capture_c, abort_c;

    logic [1:0]       al_len, al_lo;
    logic [XLEN-1:0]  al_wdata, al_rdata;
    logic [3:0]       al_wmask;

    assign mux         = mem_ctrl_i[MUX_LSB +: 2];
    assign len         = mem_ctrl_i[LEN_LSB +: 2];
    assign wen_n       = mem_ctrl_i[WEN_BIT];
    // Reset also masks the request so stall drops as soon as reset is seen.
    assign access      = valid_i & ~reset_i & ((mux == MUX_MEM) | ~wen_n);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Live instruction fields while idle, latched ones during the transaction.
    assign al_len = (state_q == S_IDLE) ? len : len_q;
    assign al_lo  = (state_q == S_IDLE) ? aluout_i[1:0] : addr_lo_q;

    mem_lane_align u_align (
        .len       (al_len),
        .addr_lo   (al_lo),
        .sign      (sign_q),
        .wdata     (wdata_i),
        .rdata     (rdata_i),
        .wdata_rep (al_wdata),
        .wmask     (al_wmask),
        .rdata_ext (al_rdata)
    );

    always_comb begin
        state_n   = state_q;
        stall_o   = 1'b0;
        go_c      = 1'b0;
        mis_det_c = 1'b0;
        capture_c = 1'b0;
        abort_c   = 1'b0;
        result_o  = (mux == MUX_IMM) ? imm_i : aluout_i;
        case (state_q)
            S_IDLE: begin
                if (misaligned_o) begin
                    result_o = '0;
                end else if (access) begin
                    stall_o = 1'b1;
                    if (is_misaligned(len, aluout_i[1:0])) begin
                        mis_det_c = 1'b1;
                    end else begin
                        go_c    = 1'b1;
                        state_n = S_REQ;
                    end
                end
            end
            S_REQ: begin
                stall_o = 1'b1;
                if (gnt_i) begin
                    if (is_store_q) begin
                        state_n = S_DONE;
                    end else if (rvalid_i) begin
                        capture_c = 1'b1;
                        state_n   = S_DONE;
                    end else begin
                        state_n = S_WAIT;
                    end
                end else if (timeout_hit) begin
                    abort_c = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_WAIT: begin
                stall_o = 1'b1;
                if (rvalid_i) begin
                    capture_c = 1'b1;
                    state_n   = S_DONE;
                end else if (timeout_hit) begin
                    abort_c = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                result_o = data_q;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            is_store_q   <= 1'b0;
            len_q        <= '0;
            sign_q       <= 1'b0;
            addr_lo_q    <= '0;
            data_q       <= '0;
            cnt_q        <= '0;
            req_o        <= 1'b0;
            we_o         <= 1'b0;
            addr_o       <= '0;
            wdata_o      <= '0;
            wmask_o      <= '0;
            done_o       <= 1'b0;
            misaligned_o <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            state_q      <= state_n;
            req_o        <= (state_n == S_REQ);
            done_o       <= (state_n == S_DONE);
            misaligned_o <= mis_det_c;
            bus_err_o    <= abort_c;
            if (go_c) begin
                is_store_q <= ~wen_n;
                len_q      <= len;
                sign_q     <= mem_ctrl_i[SIGN_BIT];
                addr_lo_q  <= aluout_i[1:0];
                addr_o     <= {aluout_i[XLEN-1:2], 2'b00};
                we_o       <= ~wen_n;
                wdata_o    <= wen_n ? '0 : al_wdata;
                wmask_o    <= wen_n ? 4'b0000 : al_wmask;
                data_q     <= '0;
                cnt_q      <= '0;
            end else begin
                if (state_n != S_REQ) begin
                    we_o    <= 1'b0;
                    wmask_o <= 4'b0000;
                end
                if (state_q == S_REQ || state_q == S_WAIT) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            if (capture_c) begin
                data_q <= al_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a short bus timeout.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [5:0]  mem_ctrl = '0;
    logic [31:0] aluout = '0;
    logic [31:0] wdata = '0;
    logic [31:0] imm = '0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;

    logic        stall, done, misaligned, bus_err, req, we;
    logic [31:0] result, addr, bus_wdata;
    logic [3:0]  wmask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .valid_i      (valid),
        .mem_ctrl_i   (mem_ctrl),
        .aluout_i     (aluout),
        .wdata_i      (wdata),
        .imm_i        (imm),
        .stall_o      (stall),
        .result_o     (result),
        .done_o       (done),
        .misaligned_o (misaligned),
        .bus_err_o    (bus_err),
        .req_o        (req),
        .we_o         (we),
        .addr_o       (addr),
        .wdata_o      (bus_wdata),
        .wmask_o      (wmask),
        .gnt_i        (gnt),
        .rvalid_i     (rvalid),
        .rdata_i      (rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ctl(input logic [1:0] mx, input logic sg,
                                       input logic [1:0] ln, input logic wn);
        return {mx, sg, ln, wn};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        aluout = 32'h77;
        repeat (2) cyc();
        check("rst_result", result, 32'h77);
        check("rst_stall", 32'(stall), 0);
        check("rst_req", 32'(req), 0);
        check("rst_addr", addr, 0);
        check("rst_flags", {28'(0), done, misaligned, bus_err, we}, 0);
        reset = 1'b0;

        // SB to 0x1003, grant in the second REQ cycle
        cyc();
        valid = 1'b1; mem_ctrl = ctl(2'd0, 1'b0, 2'd0, 1'b0);
        aluout = 32'h1003; wdata = 32'h0000_00AB;
        #1 check("sb_stall0", 32'(stall), 1);
        check("sb_req0", 32'(req), 0);
        cyc();
        check("sb_req1", 32'(req), 1);
        check("sb_stall1", 32'(stall), 1);
        check("sb_addr", addr, 32'h1000);
        check("sb_wdata", bus_wdata, 32'hABAB_ABAB);
        check("sb_wmask", 32'(wmask), 32'h8);
        check("sb_we", 32'(we), 1);
        cyc();
        check("sb_stall2", 32'(stall), 1);
        check("sb_hold_addr", addr, 32'h1000);
        gnt = 1'b1;
        cyc();
        gnt = 1'b0;
        #1 check("sb_done", 32'(done), 1);
        check("sb_stall3", 32'(stall), 0);
        check("sb_result", result, 0);
        check("sb_req3", 32'(req), 0);

        // SH to 0x0002: upper half lanes
        cyc();
        check("sb_done_clear", 32'(done), 0);
        mem_ctrl = ctl(2'd0, 1'b0, 2'd1, 1'b0); aluout = 32'h0000_0002; wdata = 32'h1234_ABCD;
        cyc();
        check("sh_wdata", bus_wdata, 32'hABCD_ABCD);
        check("sh_wmask", 32'(wmask), 32'hC);
        gnt = 1'b1;
        cyc();
        gnt = 1'b0;
        #1 check("sh_done", 32'(done), 1);

        // LH signed at 0x2002, gnt and rvalid together
        cyc();
        mem_ctrl = ctl(2'd1, 1'b1, 2'd1, 1'b1); aluout = 32'h2002;
        cyc();
        check("lh_req", 32'(req), 1);
        check("lh_we", 32'(we), 0);
        check("lh_wmask", 32'(wmask), 0);
        check("lh_addr", addr, 32'h2000);
        gnt = 1'b1; rvalid = 1'b1; rdata = 32'h8001_1234;
        cyc();
        gnt = 1'b0; rvalid = 1'b0;
        #1 check("lh_done", 32'(done), 1);
        check("lh_result", result, 32'hFFFF_8001);

        // LHU repeat
        cyc();
        mem_ctrl = ctl(2'd1, 1'b0, 2'd1, 1'b1);
        cyc();
        gnt = 1'b1; rvalid = 1'b1;
        cyc();
        gnt = 1'b0; rvalid = 1'b0;
        #1 check("lhu_result", result, 32'h0000_8001);

        // Misaligned LW at 0x2001
        cyc();
        mem_ctrl = ctl(2'd1, 1'b0, 2'd2, 1'b1); aluout = 32'h2001;
        #1 check("mis_stall0", 32'(stall), 1);
        cyc();
        check("mis_pulse", 32'(misaligned), 1);
        check("mis_stall1", 32'(stall), 0);
        check("mis_req", 32'(req), 0);
        check("mis_result", result, 0);
        valid = 1'b0;
        cyc();
        check("mis_pulse_end", 32'(misaligned), 0);
        check("mis_req_after", 32'(req), 0);

        // Pass-through ops
        valid = 1'b1; mem_ctrl = ctl(2'd0, 1'b0, 2'd0, 1'b1); aluout = 32'h55; imm = 32'h1000;
        #1 check("addi_result", result, 32'h55);
        check("addi_stall", 32'(stall), 0);
        mem_ctrl = ctl(2'd2, 1'b0, 2'd0, 1'b1);
        #1 check("auipc_result", result, 32'h1000);
        check("auipc_stall", 32'(stall), 0);
        cyc();
        check("pass_no_req", 32'(req), 0);

        // LW that is never granted: aborts after four REQ cycles
        mem_ctrl = ctl(2'd1, 1'b0, 2'd2, 1'b1); aluout = 32'h3000;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("to_req%0d", i), 32'(req), 1);
            check($sformatf("to_noerr%0d", i), 32'(bus_err), 0);
        end
        cyc();
        check("to_err", 32'(bus_err), 1);
        check("to_done", 32'(done), 1);
        check("to_result", result, 0);
        check("to_req_off", 32'(req), 0);
        valid = 1'b0;
        cyc();
        gnt = 1'b1; rvalid = 1'b1;
        cyc();
        gnt = 1'b0; rvalid = 1'b0;
        check("to_late_done", 32'(done), 0);
        check("to_late_req", 32'(req), 0);
        check("to_err_end", 32'(bus_err), 0);

        // Reset while in WAIT
        valid = 1'b1; mem_ctrl = ctl(2'd1, 1'b0, 2'd2, 1'b1); aluout = 32'h4000;
        cyc();
        gnt = 1'b1;
        cyc();
        gnt = 1'b0;
        #1 check("wait_req", 32'(req), 0);
        check("wait_stall", 32'(stall), 1);
        reset = 1'b1;
        #1 check("rst_wait_stall", 32'(stall), 0);
        check("rst_wait_req", 32'(req), 0);
        cyc();
        reset = 1'b0; valid = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        cyc();
        rvalid = 1'b0;
        check("rst_late_done", 32'(done), 0);
        check("rst_late_result", result, 32'h4000);

        // LB signed at 0x4001 through WAIT
        valid = 1'b1; mem_ctrl = ctl(2'd1, 1'b1, 2'd0, 1'b1); aluout = 32'h4001;
        cyc();
        check("lb_req", 32'(req), 1);
        gnt = 1'b1;
        cyc();
        gnt = 1'b0;
        check("lb_wait_stall", 32'(stall), 1);
        rvalid = 1'b1; rdata = 32'h0000_F500;
        cyc();
        rvalid = 1'b0;
        #1 check("lb_done", 32'(done), 1);
        check("lb_result", result, 32'hFFFF_FFF5);
        valid = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage consumer of the 6-bit MEM control field produced by the instruction decoder: {MEM_MUX[5:4], MEM_SIGN[3], MEM_LEN[2:1], MEM_WEN[0]}. Turns loads/stores into a req/gnt/rvalid data-bus transaction with byte lanes, alignment and sign/zero extension. Stalls the pipeline while a transaction is outstanding. Non-memory ops pass the ALU or immediate value straight through with zero latency.

Parameters:
TIMEOUT_CYCLES, 255, cycles in REQ+WAIT before a transaction is aborted with bus_err_o (range 1..65535)

Ports:
clk_i  input  1  clock
reset_i  input  1  asynchronous active-high reset
valid_i  input  1  MEM-stage instruction valid
mem_ctrl_i  input  6  {MEM_MUX[1:0], MEM_SIGN, MEM_LEN[1:0], MEM_WEN_n}; MUX 0=aluout, 1=memout, 2=imm; LEN 0=byte, 1=half, 2/3=word; WEN_n 0=store
aluout_i  input  32  effective address / ALU result
wdata_i  input  32  store data (rs2)
imm_i  input  32  immediate (AUIPC/LUI path)
stall_o  output  1  hold upstream stages and inputs
result_o  output  32  write-back value
done_o  output  1  one-cycle pulse when a memory op completes
misaligned_o  output  1  one-cycle pulse on a misaligned access
bus_err_o  output  1  one-cycle pulse on timeout
req_o  output  1  bus request
we_o  output  1  bus write enable
addr_o  output  32  word-aligned bus address {aluout[31:2],2'b00}
wdata_o  output  32  lane-replicated store data
wmask_o  output  4  byte-lane write mask
gnt_i  input  1  bus accepted request
rvalid_i  input  1  read data valid
rdata_i  input  32  read data

Behaviour:
- Access = valid_i & (MUX==1 | WEN_n==0). Non-access: result_o = MUX==2 ? imm_i : aluout_i (combinational), stall_o=0.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0. Detected in IDLE; no bus request; registered misaligned_o pulse next cycle; result 0; stall_o=1 in detection cycle only.
- FSM IDLE -> REQ -> (WAIT) -> DONE -> IDLE. IDLE with aligned access: latch ctrl, addr, data; stall_o=1 combinationally; next state REQ.
- REQ: req_o=1, addr_o/wdata_o/wmask_o/we_o stable until gnt_i. Store: gnt_i -> DONE. Load: gnt_i & rvalid_i -> DONE (capture data); gnt_i alone -> WAIT.
- WAIT: req_o=0; rvalid_i -> capture rdata_i, DONE.
- DONE: stall_o=0, done_o=1, result_o = extracted load data (0 for stores); -> IDLE. Upstream advances on this edge.
- Store lanes: byte wdata={4{wdata[7:0]}}, wmask=4'b0001<<addr[1:0]; half wdata={2{wdata[15:0]}}, wmask=4'b0011<<addr[1:0]; word wmask=4'b1111. Loads: wmask=0, we_o=0.
- Load extract: lane = rdata_i >> (8*addr[1:0]); byte/half sign-extended if MEM_SIGN else zero-extended.
- Timeout counter cleared on entering REQ, increments in REQ/WAIT; reaching TIMEOUT_CYCLES -> DONE with bus_err_o=1, result 0; late gnt/rvalid ignored in IDLE.
- Reset (any state, including mid-transaction): state IDLE, req_o=0, we_o=0, wmask_o=0, wdata_o=0, addr_o=0, stall_o=0, done_o=0, misaligned_o=0, bus_err_o=0, counter 0, captured data 0; result_o follows the combinational pass-through.
- valid_i ignored outside IDLE (inputs held by stall).

Decomposition:
- Shared package: MEM field bit positions, MUX encodings (aluout/memout/imm), LEN encodings, FSM state encoding.
- One sub-module: mem_lane_align (combinational store replication/mask and load extract/extend), reused by any future cache front-end.

Test Plan:
- SB, addr 0x1003, wdata 0x000000AB, gnt after 2 cycles -> addr_o 0x1000, wdata_o 0xABABABAB, wmask_o 4'b1000, we_o=1; stall_o high 3 cycles; done_o pulse, result_o 0.
- LH signed, addr 0x2002, gnt+rvalid same cycle, rdata 0x8001_1234 -> result_o 0xFFFF8001 on done_o; LHU repeat -> 0x00008001.
- LW addr 0x2001 -> no req_o, misaligned_o single pulse, stall released next cycle.
- ADDI (MUX=0) aluout 0x55 and AUIPC (MUX=2) imm 0x1000 -> result_o 0x55 / 0x1000 same cycle, stall_o never high.
- LW with gnt never asserted, TIMEOUT_CYCLES=4 -> bus_err_o after 4 REQ cycles, result 0, back to IDLE.
- Reset asserted in WAIT -> req_o/stall_o low immediately; subsequent rvalid_i ignored; next LB works normally.
